// File: rtl/p13_univ_reg_cell.sv
// p13_univ_reg_cell: WIDTH-bit universal register (hold, shift right,
// shift left, parallel load) with clock enable and synchronous reset to
// RESET_VAL. Define P13_UNIVREG_CNT_EN to add the cnt input and tc output;
// mode 00 then increments q when cnt=1.
module p13_univ_reg_cell #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
`ifdef P13_UNIVREG_CNT_EN
  input  logic             cnt,
  output logic             tc,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sr_out,
  output logic             sl_out
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Serial bit enters at the MSB; for WIDTH=1 the result is just s.
  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic s);
    logic [WIDTH-1:0] o;
    o = v >> 1;
    o[WIDTH-1] = s;
    return o;
  endfunction

  // Serial bit enters at the LSB; for WIDTH=1 the result is just s.
  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic s);
    logic [WIDTH-1:0] o;
    o = v << 1;
    o[0] = s;
    return o;
  endfunction

  logic [WIDTH-1:0] q_nxt;

  // Next-state selection by mode; enable and reset are applied in the register.
  always_comb begin
    q_nxt = q;
    unique case (mode)
      MODE_HOLD: begin
`ifdef P13_UNIVREG_CNT_EN
        if (cnt) q_nxt = q + WIDTH'(1);
`endif
      end
      MODE_SHR:  q_nxt = shift_right(q, sr_in);
      MODE_SHL:  q_nxt = shift_left(q, sl_in);
      MODE_LOAD: q_nxt = d;
      default:   q_nxt = q;
    endcase
  end

  // Register: reset beats enable, enable beats mode.
  always_ff @(posedge clk) begin
    if (r)       q <= RESET_VAL[WIDTH-1:0];
    else if (en) q <= q_nxt;
  end

  assign notq   = ~q;
  assign sr_out = q[0];
  assign sl_out = q[WIDTH-1];

`ifdef P13_UNIVREG_CNT_EN
  // Terminal count flags the edge on which an active count wraps to zero.
  assign tc = (&q) & cnt & en & (mode == MODE_HOLD);
`endif

endmodule

// File: tb/tb_p13_univ_reg_cell.sv
module tb_p13_univ_reg_cell;

  logic       clk;
  logic       r, en, sr_in, sl_in, cnt;
  logic [1:0] mode;
  logic [7:0] d, q, notq;
  logic       sr_out, sl_out;
`ifdef P13_UNIVREG_CNT_EN
  logic       tc;
`endif

  logic       r1, en1, sr1, sl1, d1, q1, notq1, sro1, slo1;
  logic [1:0] mode1;
`ifdef P13_UNIVREG_CNT_EN
  logic       cnt1, tc1;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  logic [7:0] m;

  p13_univ_reg_cell #(.WIDTH(8), .RESET_VAL(32'hA5)) dut (
    .clk(clk), .r(r), .en(en), .mode(mode), .d(d),
    .sr_in(sr_in), .sl_in(sl_in),
`ifdef P13_UNIVREG_CNT_EN
    .cnt(cnt), .tc(tc),
`endif
    .q(q), .notq(notq), .sr_out(sr_out), .sl_out(sl_out)
  );

  p13_univ_reg_cell #(.WIDTH(1), .RESET_VAL(32'h0)) dut1 (
    .clk(clk), .r(r1), .en(en1), .mode(mode1), .d(d1),
    .sr_in(sr1), .sl_in(sl1),
`ifdef P13_UNIVREG_CNT_EN
    .cnt(cnt1), .tc(tc1),
`endif
    .q(q1), .notq(notq1), .sr_out(sro1), .sl_out(slo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Drive one edge of stimulus, push the reference result, pop and check after the edge.
  task automatic cyc(input logic r_, input logic en_, input logic [1:0] mode_,
                     input logic [7:0] d_, input logic sr_, input logic sl_,
                     input logic cnt_);
    logic [7:0] e;
    logic [7:0] got;
    r = r_; en = en_; mode = mode_; d = d_; sr_in = sr_; sl_in = sl_; cnt = cnt_;
    e = m;
    if (r_) e = 8'hA5;
    else if (en_) begin
      case (mode_)
        2'b01: begin
          for (int i = 0; i < 7; i++) e[i] = m[i+1];
          e[7] = sr_;
        end
        2'b10: begin
          for (int i = 7; i > 0; i--) e[i] = m[i-1];
          e[0] = sl_;
        end
        2'b11: e = d_;
        default: begin
`ifdef P13_UNIVREG_CNT_EN
          if (cnt_) e = (m == 8'hFF) ? 8'h00 : m + 8'h01;
`endif
        end
      endcase
    end
    m = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      got = sb.pop_front();
      if (q !== got) begin
        fails++;
        $display("FAIL sb_q: q=%h expected %h", q, got);
      end
      tests++;
      if (notq !== ~got) begin
        fails++;
        $display("FAIL sb_notq: notq=%h expected %h", notq, ~got);
      end
      tests++;
      if (sr_out !== got[0] || sl_out !== got[7]) begin
        fails++;
        $display("FAIL sb_serial_out: sr_out=%b sl_out=%b expected %b %b",
                 sr_out, sl_out, got[0], got[7]);
      end
    end
  endtask

  task automatic test_reset;
    cyc(1, 0, 2'b00, 8'h00, 0, 0, 0);
    tests++;
    if (q !== 8'hA5 || notq !== 8'h5A || sr_out !== 1'b1 || sl_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: q=%h notq=%h sro=%b slo=%b expected a5 5a 1 1",
               q, notq, sr_out, sl_out);
    end
  endtask

  task automatic test_enable;
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'b11, 8'h3C, 1, 1, 1);
    tests++;
    if (q !== 8'hA5) begin
      fails++;
      $display("FAIL enable_hold: q=%h expected a5", q);
    end
  endtask

  task automatic test_shift_right;
    logic [7:0] exp_q[8];
    logic       exp_so[8];
    exp_q  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    exp_so = '{1, 0, 0, 0, 0, 0, 0, 1};
    cyc(0, 1, 2'b11, 8'h81, 1, 1, 0);
    tests++;
    if (q !== 8'h81) begin
      fails++;
      $display("FAIL load_81: q=%h expected 81", q);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (sr_out !== exp_so[i]) begin
        fails++;
        $display("FAIL shr_sr_out[%0d]: sr_out=%b expected %b", i, sr_out, exp_so[i]);
      end
      cyc(0, 1, 2'b01, 8'hFF, 0, 1, 1);
      tests++;
      if (q !== exp_q[i]) begin
        fails++;
        $display("FAIL shr_q[%0d]: q=%h expected %h", i, q, exp_q[i]);
      end
    end
  endtask

  task automatic test_shift_left;
    logic [7:0] exp_q[3];
    exp_q = '{8'h03, 8'h07, 8'h0F};
    cyc(0, 1, 2'b11, 8'h01, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'b10, 8'hFF, 0, 1, 0);
      tests++;
      if (q !== exp_q[i] || sl_out !== 1'b0) begin
        fails++;
        $display("FAIL shl[%0d]: q=%h sl_out=%b expected %h 0", i, q, sl_out, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    cyc(0, 1, 2'b11, 8'hF0, 0, 0, 0);
    cyc(0, 1, 2'b01, 8'h00, 0, 0, 0);
    cyc(0, 1, 2'b01, 8'h00, 0, 0, 0);
    cyc(1, 1, 2'b01, 8'h00, 0, 0, 1);
    tests++;
    if (q !== 8'hA5) begin
      fails++;
      $display("FAIL reset_mid_shift: q=%h expected a5", q);
    end
    cyc(0, 1, 2'b01, 8'h00, 0, 0, 0);
    tests++;
    if (q !== 8'h52) begin
      fails++;
      $display("FAIL resume_after_reset: q=%h expected 52", q);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++)
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_width1;
    d1 = 1'b1; sr1 = 1'b0; sl1 = 1'b1;
`ifdef P13_UNIVREG_CNT_EN
    cnt1 = 1'b0;
`endif
    r1 = 1'b1; en1 = 1'b1; mode1 = 2'b11;
    @(posedge clk); #1;
    tests++;
    if (q1 !== 1'b0 || notq1 !== 1'b1) begin
      fails++;
      $display("FAIL w1_reset: q=%b notq=%b expected 0 1", q1, notq1);
    end
    r1 = 1'b0; mode1 = 2'b01; sr1 = 1'b1; sl1 = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (q1 !== 1'b1 || sro1 !== 1'b1 || slo1 !== 1'b1) begin
      fails++;
      $display("FAIL w1_shr: q=%b sro=%b slo=%b expected 1 1 1", q1, sro1, slo1);
    end
    mode1 = 2'b10; sl1 = 1'b0; sr1 = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (q1 !== 1'b0 || sro1 !== 1'b0 || slo1 !== 1'b0) begin
      fails++;
      $display("FAIL w1_shl: q=%b sro=%b slo=%b expected 0 0 0", q1, sro1, slo1);
    end
  endtask

`ifdef P13_UNIVREG_CNT_EN
  task automatic test_counter;
    cyc(0, 1, 2'b11, 8'hFE, 0, 0, 0);
    r = 0; en = 1; mode = 2'b00; cnt = 1; #1;
    tests++;
    if (q !== 8'hFE || tc !== 1'b0) begin
      fails++;
      $display("FAIL cnt_fe: q=%h tc=%b expected fe 0", q, tc);
    end
    cyc(0, 1, 2'b00, 8'h00, 0, 0, 1);
    tests++;
    if (q !== 8'hFF || tc !== 1'b1) begin
      fails++;
      $display("FAIL cnt_ff: q=%h tc=%b expected ff 1", q, tc);
    end
    cyc(0, 1, 2'b00, 8'h00, 0, 0, 1);
    tests++;
    if (q !== 8'h00 || tc !== 1'b0) begin
      fails++;
      $display("FAIL cnt_wrap: q=%h tc=%b expected 00 0", q, tc);
    end
    cyc(0, 1, 2'b11, 8'hFF, 0, 0, 1);
    cnt = 0; mode = 2'b00; #1;
    tests++;
    if (tc !== 1'b0) begin
      fails++;
      $display("FAIL tc_cnt0: tc=%b expected 0", tc);
    end
    cyc(0, 1, 2'b00, 8'h00, 0, 0, 0);
    tests++;
    if (q !== 8'hFF || tc !== 1'b0) begin
      fails++;
      $display("FAIL cnt0_hold: q=%h tc=%b expected ff 0", q, tc);
    end
    cyc(0, 0, 2'b00, 8'h00, 0, 0, 1);
    tests++;
    if (q !== 8'hFF || tc !== 1'b0) begin
      fails++;
      $display("FAIL cnt_en0: q=%h tc=%b expected ff 0", q, tc);
    end
  endtask
`endif

  initial begin
    r = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sr_in = 1'b0; sl_in = 1'b0; cnt = 1'b0;
    r1 = 1'b0; en1 = 1'b0; mode1 = 2'b00; d1 = 1'b0; sr1 = 1'b0; sl1 = 1'b0;
`ifdef P13_UNIVREG_CNT_EN
    cnt1 = 1'b0;
`endif
    m = 8'h00;
    @(posedge clk); #1;
    test_reset;
    test_enable;
    test_shift_right;
    test_shift_left;
    test_reset_mid_shift;
    test_back_to_back;
    test_width1;
`ifdef P13_UNIVREG_CNT_EN
    test_counter;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
